// File: rtl/if_prefetch_stage_if.sv
// if_prefetch_stage_if
//   Instruction-memory bus between the fetch stage and the IM.
//   im_req/im_addr  : request valid and word address (held until im_gnt)
//   im_gnt          : IM accepts the request this cycle (req & gnt = issue)
//   im_rvalid/rdata : returned instruction, in issue order, >= 1 cycle after issue
//   master modport  : fetch-stage side; slave modport : IM side
interface if_prefetch_stage_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;

    modport master (output im_req, output im_addr,
                    input  im_gnt, input  im_rvalid, input im_rdata);
    modport slave  (input  im_req, input  im_addr,
                    output im_gnt, output im_rvalid, output im_rdata);
endinterface

// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage
//   Instruction-fetch stage with a prefetch queue in front of the IF/ID register.
//   It decouples the variable-latency IM from the pipeline, absorbs ID stalls and
//   flushes on branch/jump redirects. It shows a bubble (all zero) when empty.
//
//   Clock, Reset      : rising-edge clock, synchronous active-high reset
//   redirect          : taken branch/jump from ID
//   redirect_pc       : redirect target
//   id_stall          : ID cannot accept the head this cycle
//   im                : IM request/return bus (if_prefetch_stage_if.master)
//   if_valid          : head outputs hold a real instruction
//   if_Inst/PC/if_pc4 : head instruction, its address, address+4 (0 when !if_valid)
//
//   Optional macro IF_PERF_EN adds perf_fetched, perf_flushed, perf_starve counters.
//
//   state | meaning
//   IDLE  | first cycle after reset, nothing issued
//   RUN   | normal fetching
//   FLUSH | waiting for pre-redirect words to come back and be dropped
module if_prefetch_stage #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    input  logic                 id_stall,
    if_prefetch_stage_if.master  im,
    output logic                 if_valid,
    output logic [31:0]          if_Inst,
    output logic [31:0]          PC,
`ifdef IF_PERF_EN
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_flushed,
    output logic [31:0]          perf_starve,
`endif
    output logic [31:0]          if_pc4
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int SW = AW + 2;
    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);
    localparam logic [SW-1:0] DEPTH_C   = SW'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t         state_q, state_d;
    logic [31:0]    fpc_q, fpc_d;
    logic [OW-1:0]  out_cnt_q, out_cnt_d;
    logic [OW-1:0]  discard_q, discard_d;
    logic [AW-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic [31:0]    addr_q [DEPTH];
    logic [31:0]    data_q [DEPTH];

    logic           ret, issue, push, pop, drop;
    logic [31:0]    push_addr;

    // Queue entries carry the fetch address; the oldest outstanding address is
    // recovered from the head of a small in-order address FIFO below.
    logic [31:0]    ofifo_q [MAX_OUT];
    logic [$clog2(MAX_OUT+1)-1:0] ordp_q, ordp_d;   // index of oldest in-flight addr
    logic [$clog2(MAX_OUT+1)-1:0] owrp_q, owrp_d;

    // A return with nothing tracked in flight (e.g. IM not reset with us) is ignored.
    assign ret = im.im_rvalid && (out_cnt_q != '0);

    assign if_valid = (cnt_q != '0);
    assign if_Inst  = if_valid ? data_q[rd_q] : 32'h0;
    assign PC       = if_valid ? addr_q[rd_q] : 32'h0;
    assign if_pc4   = if_valid ? addr_q[rd_q] + 32'd4 : 32'h0;

    assign im.im_addr = fpc_q;
    assign push_addr  = ofifo_q[ordp_q];

    function automatic logic [$clog2(MAX_OUT+1)-1:0] oinc(input logic [$clog2(MAX_OUT+1)-1:0] p);
        return (int'(p) == MAX_OUT - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d   = state_q;
        fpc_d     = fpc_q;
        out_cnt_d = out_cnt_q;
        discard_d = discard_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        ordp_d    = ordp_q;
        owrp_d    = owrp_q;
        push      = 1'b0;
        pop       = 1'b0;
        drop      = 1'b0;

        im.im_req = (state_q == RUN) && !redirect &&
                    ((SW'(cnt_q) + SW'(out_cnt_q)) < DEPTH_C) &&
                    (out_cnt_q < MAX_OUT_C);
        issue     = im.im_req && im.im_gnt;

        if (ret)
            ordp_d = oinc(ordp_q);
        if (issue)
            owrp_d = oinc(owrp_q);

        if (redirect) begin
            // Head is not popped and a word returning now is dropped with the queue.
            drop      = ret;
            cnt_d     = '0;
            rd_d      = '0;
            wr_d      = '0;
            fpc_d     = redirect_pc;
            out_cnt_d = out_cnt_q - OW'(ret);
            discard_d = out_cnt_q - OW'(ret);
            state_d   = (out_cnt_q > OW'(ret)) ? FLUSH : RUN;
        end else begin
            if (issue)
                fpc_d = fpc_q + 32'd4;
            out_cnt_d = out_cnt_q + OW'(issue) - OW'(ret);
            if (ret) begin
                if (discard_q != '0) begin
                    drop      = 1'b1;
                    discard_d = discard_q - 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
            pop   = if_valid && !id_stall;
            cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
            if (push)
                wr_d = wr_q + 1'b1;
            if (pop)
                rd_d = rd_q + 1'b1;
            case (state_q)
                IDLE:    state_d = RUN;
                FLUSH:   if (discard_d == '0) state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            fpc_q     <= RESET_PC;
            out_cnt_q <= '0;
            discard_q <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
            ordp_q    <= '0;
            owrp_q    <= '0;
        end else begin
            state_q   <= state_d;
            fpc_q     <= fpc_d;
            out_cnt_q <= out_cnt_d;
            discard_q <= discard_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            ordp_q    <= ordp_d;
            owrp_q    <= owrp_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (issue && !Reset)
            ofifo_q[owrp_q] <= fpc_q;
        if (push && !Reset) begin
            addr_q[wr_q] <= push_addr;
            data_q[wr_q] <= im.im_rdata;
        end
    end

`ifdef IF_PERF_EN
    logic [31:0] flush_inc;
    assign flush_inc = (redirect ? 32'(cnt_q) : 32'h0) + 32'(drop);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
            perf_starve  <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(push);
            perf_flushed <= perf_flushed + flush_inc;
            perf_starve  <= perf_starve + 32'(state_q == RUN && !if_valid && !id_stall);
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// tb_if_prefetch_stage
//   Randomised bench for if_prefetch_stage. An in-order IM model with random grant
//   and latency serves fetches; the expected instruction stream is the program-order
//   address sequence restarting at every redirect/reset target, with the instruction
//   word a fixed function of its address.
module tb_if_prefetch_stage;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_Inst, PC, if_pc4;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetched, perf_flushed, perf_starve;
`endif

    if_prefetch_stage_if im_bus ();

    if_prefetch_stage #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_stall    (id_stall),
        .im          (im_bus),
        .if_valid    (if_valid),
        .if_Inst     (if_Inst),
        .PC          (PC),
`ifdef IF_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed),
        .perf_starve (perf_starve),
`endif
        .if_pc4      (if_pc4)
    );

    always #5 Clock = ~Clock;

    typedef struct {logic [31:0] addr; int rdy;} pend_t;
    pend_t       pending[$];
    logic [31:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int max_pend = 0;

    logic        prev_rst = 1'b0, prev_rd = 1'b0, prev_hold = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock cycle of stimulus plus the IM model.
    task automatic step(input logic rst, input logic rd, input logic [31:0] tgt,
                        input logic st, input logic g, input int lat_lo, input int lat_hi);
        @(negedge Clock);
        Reset       = rst;
        redirect    = rd;
        redirect_pc = tgt;
        id_stall    = st;
        im_bus.im_gnt = g;
        im_bus.im_rvalid = 1'b0;
        im_bus.im_rdata  = $urandom;
        if (rst) begin
            pending.delete();
            exp_q.delete();
            exp_q.push_back(RESET_PC);
        end else begin
            if (pending.size() > 0 && pending[0].rdy <= cyc) begin
                im_bus.im_rvalid = 1'b1;
                im_bus.im_rdata  = mem(pending[0].addr);
                void'(pending.pop_front());
            end
            if (rd) begin
                exp_q.delete();
                exp_q.push_back(tgt);
            end
        end
        while (exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd4);
        #1;
        if (prev_rst) begin
            chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
            chk("rst_if_Inst", if_Inst, 32'h0);
            chk("rst_PC", PC, 32'h0);
            chk("rst_if_pc4", if_pc4, 32'h0);
            chk("rst_im_req", {31'h0, im_bus.im_req}, 32'h0);
        end
        if (prev_rd && !prev_rst && !rst)
            chk("post_redirect_empty", {31'h0, if_valid}, 32'h0);
        if (prev_hold && !rst && !rd) begin
            chk("req_held", {31'h0, im_bus.im_req}, 32'h1);
            chk("addr_held", im_bus.im_addr, prev_addr);
        end
        if (!rst && im_bus.im_req && g) begin
            pending.push_back('{addr: im_bus.im_addr, rdy: cyc + int'($urandom_range(lat_hi, lat_lo))});
            if (pending.size() > max_pend) max_pend = pending.size();
        end
        prev_rst  = rst;
        prev_rd   = rd && !rst;
        prev_hold = im_bus.im_req && !g && !rd && !rst;
        prev_addr = im_bus.im_addr;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1, 1);
    endtask

    // Monitor: compares every presented head against the scoreboard front, pops on consume.
    initial begin
        forever begin
            @(negedge Clock);
            #2;
            if (!Reset && !redirect) begin
                if (!if_valid) begin
                    if (if_Inst !== 32'h0 || PC !== 32'h0 || if_pc4 !== 32'h0) begin
                        chk("bubble_Inst", if_Inst, 32'h0);
                        chk("bubble_PC", PC, 32'h0);
                    end
                end else if (exp_q.size() == 0) begin
                    chk("scoreboard_nonempty", 32'h0, 32'h1);
                end else begin
                    chk("head_PC", PC, exp_q[0]);
                    chk("head_Inst", if_Inst, mem(exp_q[0]));
                    chk("head_pc4", if_pc4, exp_q[0] + 32'd4);
                    if (!id_stall) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] held_pc;
        int          waited;
        im_bus.im_gnt = 1'b0;
        im_bus.im_rvalid = 1'b0;
        im_bus.im_rdata = 32'h0;

        // Reset, then full-rate fetch: one instruction per cycle from cycle 3.
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1, 1);
        for (int k = 0; k < 25; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1, 1);
            if (k >= 3) chk("stream_valid", {31'h0, if_valid}, 32'h1);
        end

        // Stall six cycles: queue fills, requests stop, head held.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1, 1);
        held_pc = PC;
        for (int k = 1; k < 6; k++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1, 1);
        chk("stall_req_dropped", {31'h0, im_bus.im_req}, 32'h0);
        chk("stall_head_held", PC, held_pc);
        chk("stall_valid", {31'h0, if_valid}, 32'h1);
        run(10);

        // Redirect to 0x40 with two requests outstanding.
        waited = 0;
        while (pending.size() != 2 && waited < 20) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3, 3);
            waited++;
        end
        chk("two_outstanding", pending.size(), 32'd2);
        step(1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 1, 1);
        run(15);

        // Redirect while a pop and a push coincide.
        run(6);
        step(1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 1, 1);
        run(8);

        // Grant withheld five cycles: request stable, queue drains.
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1, 1);
        chk("gnt_low_drained", {31'h0, if_valid}, 32'h0);
        run(10);

        // Address wrap at 2^32.
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 1, 1);
        run(10);

        // Reset mid-burst with the queue partially full.
        run(5);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1, 1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1, 1);
        run(10);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            logic        r_rst, r_rd, r_st, r_g;
            logic [31:0] r_tgt;
            r_rst = ($urandom_range(999, 0) < 3);
            r_rd  = ($urandom_range(99, 0) < 5);
            r_tgt = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            r_st  = ($urandom_range(99, 0) < 30);
            r_g   = ($urandom_range(99, 0) < 70);
            step(r_rst, r_rd, r_tgt, r_st, r_g, 1, 4);
        end
        run(20);

        chk("max_outstanding_ok", {31'h0, max_pend <= MAX_OUT}, 32'h1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
